// File: rtl/reg_scoreboard_decoder.sv
// Register busy scoreboard with one-hot issue/writeback decode, RAW/WAW hazard
// detection with writeback bypass, and registered write enables.

module reg_sb_entry (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic flush_i,
    input  logic set_i,
    input  logic clr_i,
    output logic busy_d_o,
    output logic busy_o,
    output logic issue_oh_o,
    output logic wb_oh_o
);
    logic busy_q, issue_oh_q, wb_oh_q;

    // A new claim beats a same-cycle retire: the new producer owns the register.
    assign busy_d_o = flush_i ? 1'b0 : ((busy_q & ~clr_i) | set_i);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            busy_q     <= 1'b0;
            issue_oh_q <= 1'b0;
            wb_oh_q    <= 1'b0;
        end else begin
            busy_q     <= busy_d_o;
            issue_oh_q <= set_i;
            wb_oh_q    <= clr_i;
        end
    end

    assign busy_o     = busy_q;
    assign issue_oh_o = issue_oh_q;
    assign wb_oh_o    = wb_oh_q;
endmodule

module reg_scoreboard_decoder #(
    parameter int ADDR_W   = 5,
    parameter bit ZERO_EN  = 1'b1,
    parameter int ZERO_REG = (1 << ADDR_W) - 1,
    localparam int NREG    = 1 << ADDR_W,
    localparam int CW      = ADDR_W + 1
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              flush_i,
    input  logic              issue_en_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_a_i,
    input  logic [ADDR_W-1:0] rd_addr_b_i,
    input  logic              wb_en_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    output logic              hazard_a_o,
    output logic              hazard_b_o,
    output logic              waw_o,
    output logic              issue_accept_o,
    output logic [NREG-1:0]   busy_o,
    output logic [CW-1:0]     busy_count_o,
    output logic [NREG-1:0]   issue_onehot_o,
    output logic [NREG-1:0]   wb_onehot_o
);
    function automatic logic [NREG-1:0] decode(input logic [ADDR_W-1:0] a);
        logic [NREG-1:0] d;
        d    = '0;
        d[a] = 1'b1;
        if (ZERO_EN && (int'(a) == ZERO_REG)) d = '0;
        return d;
    endfunction

    logic [NREG-1:0] set_v, clr_v, busy_d;
    logic [CW-1:0]   count_d, count_q;
    logic            byp_a, byp_b, byp_w;

    // Writeback this cycle forwards the value, so it masks the busy bit.
    assign byp_a = wb_en_i && (wb_addr_i == rd_addr_a_i);
    assign byp_b = wb_en_i && (wb_addr_i == rd_addr_b_i);
    assign byp_w = wb_en_i && (wb_addr_i == issue_addr_i);

    assign hazard_a_o     = busy_o[rd_addr_a_i] & ~byp_a;
    assign hazard_b_o     = busy_o[rd_addr_b_i] & ~byp_b;
    assign waw_o          = issue_en_i & busy_o[issue_addr_i] & ~byp_w;
    assign issue_accept_o = issue_en_i & ~(hazard_a_o | hazard_b_o | waw_o) & ~flush_i;

    assign set_v = issue_accept_o ? decode(issue_addr_i) : '0;
    assign clr_v = wb_en_i ? decode(wb_addr_i) : '0;

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        reg_sb_entry u_ent (
            .clk_i      (clk_i),
            .reset_n_i  (reset_n_i),
            .flush_i    (flush_i),
            .set_i      (set_v[r]),
            .clr_i      (clr_v[r]),
            .busy_d_o   (busy_d[r]),
            .busy_o     (busy_o[r]),
            .issue_oh_o (issue_onehot_o[r]),
            .wb_oh_o    (wb_onehot_o[r])
        );
    end

    // Count the next-state vector so the registered count tracks busy exactly.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < NREG; i++) count_d = count_d + CW'(busy_d[i]);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) count_q <= '0;
        else            count_q <= count_d;
    end

    assign busy_count_o = count_q;
endmodule

// File: tb/tb_reg_scoreboard_decoder.sv
// Directed bench over three configurations; stimulus pushes expected results,
// a monitor pops and compares them each cycle.

module tb_reg_scoreboard_decoder;
    typedef struct {
        logic        ha, hb, waw, acc;
        logic [63:0] busy;
        logic [6:0]  cnt;
        logic [63:0] ioh, woh;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n, flush, ie, we;
    logic [5:0] ia, ra, rb, wa;
    int cfg;
    int n_tests = 0;
    int n_fail  = 0;
    exp_t q[$];
    event drv_ev;

    always #5 clk = ~clk;

    logic ha0, hb0, waw0, acc0; logic [31:0] busy0, ioh0, woh0; logic [5:0] cnt0;
    logic ha1, hb1, waw1, acc1; logic [7:0]  busy1, ioh1, woh1; logic [3:0] cnt1;
    logic ha2, hb2, waw2, acc2; logic [63:0] busy2, ioh2, woh2; logic [6:0] cnt2;

    reg_scoreboard_decoder #(.ADDR_W(5)) dut0 (
        .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush), .issue_en_i(ie),
        .issue_addr_i(ia[4:0]), .rd_addr_a_i(ra[4:0]), .rd_addr_b_i(rb[4:0]),
        .wb_en_i(we), .wb_addr_i(wa[4:0]), .hazard_a_o(ha0), .hazard_b_o(hb0),
        .waw_o(waw0), .issue_accept_o(acc0), .busy_o(busy0), .busy_count_o(cnt0),
        .issue_onehot_o(ioh0), .wb_onehot_o(woh0));

    reg_scoreboard_decoder #(.ADDR_W(3), .ZERO_EN(1'b0)) dut1 (
        .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush), .issue_en_i(ie),
        .issue_addr_i(ia[2:0]), .rd_addr_a_i(ra[2:0]), .rd_addr_b_i(rb[2:0]),
        .wb_en_i(we), .wb_addr_i(wa[2:0]), .hazard_a_o(ha1), .hazard_b_o(hb1),
        .waw_o(waw1), .issue_accept_o(acc1), .busy_o(busy1), .busy_count_o(cnt1),
        .issue_onehot_o(ioh1), .wb_onehot_o(woh1));

    reg_scoreboard_decoder #(.ADDR_W(6)) dut2 (
        .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush), .issue_en_i(ie),
        .issue_addr_i(ia), .rd_addr_a_i(ra), .rd_addr_b_i(rb),
        .wb_en_i(we), .wb_addr_i(wa), .hazard_a_o(ha2), .hazard_b_o(hb2),
        .waw_o(waw2), .issue_accept_o(acc2), .busy_o(busy2), .busy_count_o(cnt2),
        .issue_onehot_o(ioh2), .wb_onehot_o(woh2));

    logic s_ha, s_hb, s_waw, s_acc;
    logic [63:0] s_busy, s_ioh, s_woh;
    logic [6:0]  s_cnt;
    always_comb begin
        s_ha = ha0; s_hb = hb0; s_waw = waw0; s_acc = acc0;
        s_busy = {32'b0, busy0}; s_ioh = {32'b0, ioh0}; s_woh = {32'b0, woh0};
        s_cnt = {1'b0, cnt0};
        if (cfg == 1) begin
            s_ha = ha1; s_hb = hb1; s_waw = waw1; s_acc = acc1;
            s_busy = {56'b0, busy1}; s_ioh = {56'b0, ioh1}; s_woh = {56'b0, woh1};
            s_cnt = {3'b0, cnt1};
        end else if (cfg == 2) begin
            s_ha = ha2; s_hb = hb2; s_waw = waw2; s_acc = acc2;
            s_busy = busy2; s_ioh = ioh2; s_woh = woh2; s_cnt = cnt2;
        end
    end

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cfg%0d %s: got %h expected %h", cfg, nm, act, exp);
        end
    endfunction

    function automatic exp_t ex(input logic ha, hb, waw, acc, input logic [63:0] busy,
                                input logic [6:0] cnt, input logic [63:0] ioh, woh);
        exp_t e;
        e.ha = ha; e.hb = hb; e.waw = waw; e.acc = acc;
        e.busy = busy; e.cnt = cnt; e.ioh = ioh; e.woh = woh;
        return e;
    endfunction

    task automatic idle_inputs();
        flush = 0; ie = 0; we = 0; ia = 0; ra = 0; rb = 0; wa = 0;
    endtask

    task automatic step(input logic i_ie, input logic [5:0] i_ia, i_ra, i_rb,
                        input logic i_we, input logic [5:0] i_wa, input logic i_fl, input exp_t e);
        @(negedge clk);
        ie = i_ie; ia = i_ia; ra = i_ra; rb = i_rb; we = i_we; wa = i_wa; flush = i_fl;
        q.push_back(e);
        -> drv_ev;
        @(posedge clk);
    endtask

    task automatic do_reset(input int c);
        @(negedge clk);
        idle_inputs();
        reset_n = 0;
        cfg = c;
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic async_rst(input logic [63:0] busy_before);
        @(negedge clk);
        idle_inputs();
        #2;
        chk("busy_pre_reset", s_busy, busy_before);
        reset_n = 0;
        #1;
        chk("async_busy", s_busy, 64'h0);
        chk("async_count", 64'(s_cnt), 64'h0);
        chk("async_issue_onehot", s_ioh, 64'h0);
        chk("async_wb_onehot", s_woh, 64'h0);
        @(negedge clk);
        reset_n = 1;
    endtask

    // Monitor: combinational outputs sampled after the drive, registered ones after the edge.
    initial begin
        exp_t e;
        logic c_ha, c_hb, c_waw, c_acc;
        forever begin
            @(drv_ev);
            #1;
            c_ha = s_ha; c_hb = s_hb; c_waw = s_waw; c_acc = s_acc;
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL cfg%0d queue: got empty expected entry", cfg);
            end else begin
                e = q.pop_front();
                chk("hazard_a", 64'(c_ha), 64'(e.ha));
                chk("hazard_b", 64'(c_hb), 64'(e.hb));
                chk("waw", 64'(c_waw), 64'(e.waw));
                chk("issue_accept", 64'(c_acc), 64'(e.acc));
                chk("busy", s_busy, e.busy);
                chk("busy_count", 64'(s_cnt), 64'(e.cnt));
                chk("issue_onehot", s_ioh, e.ioh);
                chk("wb_onehot", s_woh, e.woh);
            end
        end
    end

    initial begin
        cfg = 0;
        reset_n = 0;
        idle_inputs();
        // Reset held with toggling inputs: state stays clear.
        step(1, 3, 3, 3, 1, 4, 0, ex(0, 0, 0, 1, 0, 0, 0, 0));
        step(1, 7, 1, 2, 1, 7, 1, ex(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk); idle_inputs(); reset_n = 1;
        step(0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0));
        // Claim X3, RAW on A, bypass on writeback.
        step(1, 3, 0, 1, 0, 0, 0, ex(0, 0, 0, 1, 64'h8, 1, 64'h8, 0));
        step(1, 4, 3, 0, 0, 0, 0, ex(1, 0, 0, 0, 64'h8, 1, 0, 0));
        step(1, 4, 3, 0, 1, 3, 0, ex(0, 0, 0, 1, 64'h10, 1, 64'h10, 64'h8));
        // WAW, then same-address issue+writeback.
        step(1, 5, 0, 0, 0, 0, 0, ex(0, 0, 0, 1, 64'h30, 2, 64'h20, 0));
        step(1, 5, 0, 0, 0, 0, 0, ex(0, 0, 1, 0, 64'h30, 2, 0, 0));
        step(1, 5, 0, 0, 1, 5, 0, ex(0, 0, 0, 1, 64'h30, 2, 64'h20, 64'h20));
        step(0, 0, 0, 4, 0, 0, 0, ex(0, 1, 0, 0, 64'h30, 2, 0, 0));
        // Zero register XZR and writeback to an idle register.
        step(1, 31, 31, 31, 1, 31, 0, ex(0, 0, 0, 1, 64'h30, 2, 0, 0));
        step(0, 0, 0, 0, 1, 7, 0, ex(0, 0, 0, 0, 64'h30, 2, 0, 64'h80));
        // Fill to 10 busy, then flush with a pending issue and a writeback.
        for (int i = 6; i <= 13; i++)
            step(1, 6'(i), 6'(i), 6'(i), 0, 0, 0,
                 ex(0, 0, 0, 1, 64'h30 | (((64'h1 << (i + 1)) - 1) & ~64'h3F), 7'(i - 3), 64'h1 << i, 0));
        step(1, 20, 0, 0, 1, 4, 1, ex(0, 0, 0, 0, 0, 0, 0, 64'h10));
        step(0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 4; i++)
            step(1, 6'(i), 6'(i), 6'(i), 0, 0, 0,
                 ex(0, 0, 0, 1, ((64'h1 << (i + 1)) - 1) & ~64'h1, 7'(i), 64'h1 << i, 0));
        async_rst(64'h1E);

        // ADDR_W=3, no zero register: index 7 is ordinary, count reaches NREG.
        do_reset(1);
        step(1, 7, 0, 0, 0, 0, 0, ex(0, 0, 0, 1, 64'h80, 1, 64'h80, 0));
        step(1, 0, 7, 0, 0, 0, 0, ex(1, 0, 0, 0, 64'h80, 1, 0, 0));
        for (int i = 0; i <= 6; i++)
            step(1, 6'(i), 6'(i), 6'(i), 0, 0, 0,
                 ex(0, 0, 0, 1, 64'h80 | ((64'h1 << (i + 1)) - 1), 7'(i + 2), 64'h1 << i, 0));
        step(0, 0, 0, 0, 1, 7, 0, ex(1, 1, 0, 0, 64'h7F, 7, 0, 64'h80));
        async_rst(64'h7F);

        // ADDR_W=6, zero register at 63.
        do_reset(2);
        step(1, 40, 0, 0, 0, 0, 0, ex(0, 0, 0, 1, 64'h1 << 40, 1, 64'h1 << 40, 0));
        step(1, 63, 0, 0, 0, 0, 0, ex(0, 0, 0, 1, 64'h1 << 40, 1, 0, 0));
        step(0, 0, 63, 40, 0, 0, 0, ex(0, 1, 0, 0, 64'h1 << 40, 1, 0, 0));
        step(1, 0, 63, 40, 1, 40, 0, ex(0, 0, 0, 1, 64'h1, 1, 64'h1, 64'h1 << 40));
        async_rst(64'h1);

        for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        #20;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
